// File: rtl/rst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Releases NUM_STAGES reset domains in order once the PLL lock
//               has been stable, re-asserts them all on lock loss, external or
//               software reset, and records the cause of every reset.
// Revision    : 1.0  initial release
// ============================================================================
module rst_sequencer #(
    parameter int unsigned NUM_STAGES         = 3,
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned STAGE_DELAY        = 8,
    parameter int unsigned MIN_HOLD           = 16
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  pll_locked_i,
    input  logic                  ext_rst_i,
    input  logic                  sw_rst_req_i,
    input  logic                  rst_cause_clr_i,
    output logic [NUM_STAGES-1:0] stage_rst_n_o,
    output logic [3:0]            rst_cause_o,
    output logic                  seq_busy_o
);

    // Counter is sized for the longest of the three intervals it measures.
    localparam int unsigned c_MAX_AB  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int unsigned c_MAX_CNT = (c_MAX_AB > MIN_HOLD) ? c_MAX_AB : MIN_HOLD;
    localparam int unsigned c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam int unsigned c_IDX_W   = $clog2(NUM_STAGES) + 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(MIN_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(STAGE_DELAY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;
    logic [c_IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_n_q, stage_rst_n_d;
    logic [3:0]              rst_cause_q, rst_cause_d;
    logic                    seq_busy_q, seq_busy_d;
    logic                    lock_meta_q, lock_meta_d;
    logic                    lock_s_q, lock_s_d;
    logic                    w_lock_lost;
    logic [3:0]              w_event_bits;

    // Next-state, counter, stage and cause logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_rst_n_d = stage_rst_n_q;
        rst_cause_d   = rst_cause_clr_i ? 4'b0000 : rst_cause_q;
        lock_meta_d   = pll_locked_i;
        lock_s_d      = lock_meta_q;

        // Lock dropping while waiting for lock only restarts the stability count.
        w_lock_lost  = !lock_s_q && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
        // HOLD already keeps everything asserted, so requests there are not new events.
        w_event_bits = (state_q == ST_HOLD) ? 4'b0000
                                            : {sw_rst_req_i, ext_rst_i, w_lock_lost, 1'b0};

        case (state_q)
            ST_HOLD: begin
                stage_rst_n_d = '0;
                if (ext_rst_i || sw_rst_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == c_HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_LOCK_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == c_STAGE_LAST) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == c_IDX_W'(k)) begin
                            stage_rst_n_d[k] = 1'b1;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (idx_q == c_IDX_LAST) begin
                        state_d = ST_RUN;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                stage_rst_n_d = '1;
            end
            default: begin
                state_d       = ST_HOLD;
                cnt_d         = '0;
                idx_d         = '0;
                stage_rst_n_d = '0;
            end
        endcase

        // Any reset event overrides the normal progression and drops all domains at once.
        if (w_event_bits != 4'b0000) begin
            state_d       = ST_HOLD;
            cnt_d         = '0;
            idx_d         = '0;
            stage_rst_n_d = '0;
            rst_cause_d   = rst_cause_d | w_event_bits;
        end

        seq_busy_d = (state_d != ST_RUN);
    end

    // State, counters, registered outputs and lock synchroniser.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            stage_rst_n_q <= '0;
            rst_cause_q   <= 4'b0001;
            seq_busy_q    <= 1'b1;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_rst_n_q <= stage_rst_n_d;
            rst_cause_q   <= rst_cause_d;
            seq_busy_q    <= seq_busy_d;
            lock_meta_q   <= lock_meta_d;
            lock_s_q      <= lock_s_d;
        end
    end

    assign stage_rst_n_o = stage_rst_n_q;
    assign rst_cause_o   = rst_cause_q;
    assign seq_busy_o    = seq_busy_q;

endmodule
`default_nettype wire
